// File: rtl/shadow_chain_collector.sv
// Collects the serial chains of one shadow capture instance, packs the bits into words and queues them for readout.
// Optional watchdog abort: define SHADOW_COLLECT_TIMEOUT_EN.
module shadow_chain_collector #(
  parameter int CHAINS      = 2,
  parameter int WORD_W      = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  output logic [CHAINS-1:0]                      dump_en,
  input  logic [CHAINS-1:0]                      ch_in,
  input  logic [CHAINS-1:0]                      ch_in_vld,
  input  logic [CHAINS-1:0]                      ch_in_done,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [WORD_W-1:0]                      out_data,
  output logic [$clog2(WORD_W+1)-1:0]            out_nbits,
  output logic [(CHAINS > 1 ? $clog2(CHAINS) : 1)-1:0] out_chain,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   ovf,
  output logic                                   tmo
);
  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int IDX_W = (CHAINS > 1) ? $clog2(CHAINS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ENT_W = WORD_W + CNT_W + IDX_W + 1;

  typedef enum logic [2:0] {IDLE, ARM, COLLECT, GAP, FIN} state_t;

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s, cnt_inc_s;
  logic [WORD_W-1:0]  sh_r, sh_s, data_s;
  logic               bit_s, vld_s, dn_s;
  logic               push_s, clr_s, tmo_set_s;
  logic [ENT_W-1:0]   push_word_s;
  logic [ENT_W-1:0]   mem_r [FIFO_DEPTH];
  logic [AW:0]        wr_ptr_r, rd_ptr_r;
  logic               full_s, pop_s, push_ok_s;
  logic [ENT_W-1:0]   head_s;
  logic               tmo_hit_s;

  assign bit_s     = ch_in[idx_r];
  assign vld_s     = ch_in_vld[idx_r];
  assign dn_s      = ch_in_done[idx_r];
  assign data_s    = vld_s ? (sh_r | (WORD_W'(bit_s) << cnt_r)) : sh_r;
  assign cnt_inc_s = cnt_r + CNT_W'(vld_s);

`ifdef SHADOW_COLLECT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_r;
  logic            tmo_r;

  assign tmo_hit_s = !vld_s && !dn_s && (wd_r == WD_W'(TIMEOUT_CYC - 1));
  assign tmo       = tmo_r;

  // Watchdog: idle COLLECT cycles on the active chain, plus sticky abort flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_r  <= '0;
      tmo_r <= 1'b0;
    end else begin
      if (state_r != COLLECT || vld_s || dn_s) wd_r <= '0;
      else                                     wd_r <= wd_r + WD_W'(1);
      if (clr_s)          tmo_r <= 1'b0;
      else if (tmo_set_s) tmo_r <= 1'b1;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
  assign tmo       = 1'b0;
`endif

  // Next-state, packing and push decode
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    cnt_s       = cnt_r;
    sh_s        = sh_r;
    push_s      = 1'b0;
    push_word_s = '0;
    clr_s       = 1'b0;
    tmo_set_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = ARM;
          idx_s   = '0;
          cnt_s   = '0;
          sh_s    = '0;
          clr_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ARM: state_s = COLLECT;
      COLLECT: begin
        if (dn_s) begin
          // a bit arriving with done belongs to the final word
          push_s      = 1'b1;
          push_word_s = {data_s, cnt_inc_s, idx_r, 1'b1};
          cnt_s       = '0;
          sh_s        = '0;
          state_s     = GAP;
        end else if (vld_s && cnt_inc_s == CNT_W'(WORD_W)) begin
          push_s      = 1'b1;
          push_word_s = {data_s, cnt_inc_s, idx_r, 1'b0};
          cnt_s       = '0;
          sh_s        = '0;
        end else if (tmo_hit_s) begin
          push_s      = 1'b1;
          push_word_s = {sh_r, cnt_r, idx_r, 1'b1};
          cnt_s       = '0;
          sh_s        = '0;
          tmo_set_s   = 1'b1;
          state_s     = FIN;
        end else begin
          cnt_s = cnt_inc_s;
          sh_s  = data_s;
        end
      end
      GAP: begin
        if (idx_r == IDX_W'(CHAINS - 1)) begin
          state_s = FIN;
        end else begin
          idx_s   = idx_r + IDX_W'(1);
          state_s = COLLECT;
        end
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Control state and registered control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= '0;
      cnt_r   <= '0;
      sh_r    <= '0;
      dump_en <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      sh_r    <= sh_s;
      dump_en <= (state_s == COLLECT) ? (CHAINS'(1) << idx_s) : '0;
      busy    <= (state_s == ARM) || (state_s == COLLECT) || (state_s == GAP);
      done    <= (state_s == FIN);
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign out_valid = (wr_ptr_r != rd_ptr_r);
  assign pop_s     = out_valid && out_ready;
  assign push_ok_s = push_s && (!full_s || pop_s);
  assign head_s    = out_valid ? mem_r[rd_ptr_r[AW-1:0]] : '0;
  assign {out_data, out_nbits, out_chain, out_last} = head_s;

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= push_word_s;
  end

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      if (clr_s)                              ovf <= 1'b0;
      else if (push_s && full_s && !pop_s)    ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_shadow_chain_collector.sv
// Scoreboard bench for shadow_chain_collector (CHAINS=2, WORD_W=8, FIFO_DEPTH=4, TIMEOUT_CYC=16).
module tb_shadow_chain_collector;
  localparam int CHAINS = 2, WORD_W = 8, FIFO_DEPTH = 4, TIMEOUT_CYC = 16;
  localparam int ENT_W = 14;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [1:0] ch_in = '0, ch_in_vld = '0, ch_in_done = '0;
  logic [1:0] dump_en;
  logic       out_valid, out_last, busy, done, ovf, tmo;
  logic [7:0] out_data;
  logic [3:0] out_nbits;
  logic [0:0] out_chain;

  int checks = 0, errors = 0;
  logic [ENT_W-1:0] exp_q[$];
  int push_cnt = 0, keep_cap = 1000;
  int done_cnt = 0, pop_cnt = 0, en1_cnt = 0;

  shadow_chain_collector #(.CHAINS(CHAINS), .WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH),
                           .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .dump_en(dump_en), .ch_in(ch_in),
    .ch_in_vld(ch_in_vld), .ch_in_done(ch_in_done), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_nbits(out_nbits),
    .out_chain(out_chain), .out_last(out_last), .busy(busy), .done(done),
    .ovf(ovf), .tmo(tmo));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Pops are compared against the scoreboard on the falling edge
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (dump_en[1]) en1_cnt++;
    if (!reset && out_valid && out_ready) begin
      pop_cnt++;
      if (exp_q.size() == 0) check_eq("sb_extra", 32'(out_valid), 32'd0);
      else check_eq("word", 32'({out_data, out_nbits, out_chain, out_last}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic expect_word(input logic [7:0] d, input int nb, input int c, input bit last);
    if (push_cnt < keep_cap) exp_q.push_back({d, 4'(nb), 1'(c), last});
    push_cnt++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_dump(input int c);
    for (int i = 0; i < 20; i++) begin
      if (dump_en == 2'(1 << c)) break;
      tick();
    end
    check_eq("dump_en_wait", 32'(dump_en), 32'(1 << c));
  endtask

  task automatic drive_chain(input int c, input logic [63:0] bits, input int n,
                             input bit done_same, input int ready_idx, input bit noise);
    logic [7:0] acc;
    int k;
    bit isdone;
    wait_dump(c);
    acc = '0; k = 0;
    for (int i = 0; i < n; i++) begin
      isdone = done_same && (i == n - 1);
      ch_in = '0; ch_in_vld = '0; ch_in_done = '0;
      ch_in[c] = bits[i]; ch_in_vld[c] = 1'b1; ch_in_done[c] = isdone;
      if (noise) begin
        ch_in_vld[1-c] = 1'b1; ch_in[1-c] = ~bits[i]; ch_in_done[1-c] = (i == 2);
        start = (i == 1);
      end
      if (i == ready_idx) out_ready = 1'b1;
      acc[k] = bits[i]; k++;
      if (k == 8) begin expect_word(acc, 8, c, isdone); acc = '0; k = 0; end
      else if (isdone) expect_word(acc, k, c, 1'b1);
      tick();
    end
    ch_in = '0; ch_in_vld = '0; ch_in_done = '0; start = 1'b0;
    if (!done_same) begin
      ch_in_done[c] = 1'b1;
      expect_word(acc, k, c, 1'b1);
      tick();
      ch_in_done = '0;
    end
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 60; i++) begin
      if (done_cnt > base) break;
      tick();
    end
    repeat (3) tick();
    check_eq("done_once", 32'(done_cnt - base), 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base, pbase, ebase;
    logic [63:0] r;
    repeat (3) tick();
    check_eq("rst_dump_en", 32'(dump_en), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_tmo", 32'(tmo), 32'd0);
    check_eq("rst_out_data", 32'({out_data, out_nbits, out_chain, out_last}), 32'd0);
    reset = 1'b0; tick();

    // basic packing and chain sequencing
    base = done_cnt;
    pulse_start();
    check_eq("busy_after_start", 32'(busy), 32'd1);
    drive_chain(0, 64'h8D, 8, 1'b0, -1, 1'b0);
    check_eq("gap_dump_en", 32'(dump_en), 32'd0);
    tick();
    check_eq("chain1_dump_en", 32'(dump_en), 32'd2);
    drive_chain(1, 64'h3, 3, 1'b1, -1, 1'b0);
    wait_done(base);
    check_eq("busy_idle", 32'(busy), 32'd0);
    wait_drain();

    // overflow: consumer stalled for the whole dump
    out_ready = 1'b0; keep_cap = 4; push_cnt = 0; base = done_cnt;
    r = {$urandom(), $urandom()};
    pulse_start();
    drive_chain(0, r, 40, 1'b0, -1, 1'b0);
    drive_chain(1, 64'h0, 0, 1'b0, -1, 1'b0);
    wait_done(base);
    check_eq("ovf_set", 32'(ovf), 32'd1);
    pbase = pop_cnt;
    out_ready = 1'b1;
    wait_drain();
    repeat (3) tick();
    check_eq("ovf_pops", 32'(pop_cnt - pbase), 32'd4);
    check_eq("ovf_empty", 32'(out_valid), 32'd0);
    check_eq("ovf_sticky", 32'(ovf), 32'd1);
    keep_cap = 1000;

    // full FIFO, push and pop together on the 5th word
    out_ready = 1'b0; base = done_cnt;
    r = {$urandom(), $urandom()};
    pulse_start();
    check_eq("ovf_cleared", 32'(ovf), 32'd0);
    drive_chain(0, r, 40, 1'b1, 39, 1'b0);
    drive_chain(1, 64'h0, 0, 1'b0, -1, 1'b0);
    wait_done(base);
    wait_drain();
    check_eq("full_no_ovf", 32'(ovf), 32'd0);

    // reset mid-dump
    base = done_cnt;
    pulse_start();
    wait_dump(0);
    for (int i = 0; i < 5; i++) begin
      ch_in_vld = 2'b01; ch_in = 2'($urandom_range(0, 1)); tick();
    end
    ch_in_vld = '0; ch_in = '0;
    reset = 1'b1; tick();
    check_eq("mid_rst_dump_en", 32'(dump_en), 32'd0);
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0; tick();
    check_eq("mid_rst_no_done", 32'(done_cnt - base), 32'd0);
    pulse_start();
    drive_chain(0, 64'h5, 3, 1'b1, -1, 1'b0);
    drive_chain(1, 64'h0, 0, 1'b0, -1, 1'b0);
    wait_done(base);
    wait_drain();

    // other-chain strobes and start while busy are ignored
    base = done_cnt;
    pulse_start();
    drive_chain(0, 64'hA5C3, 12, 1'b0, -1, 1'b1);
    drive_chain(1, 64'h16, 5, 1'b0, -1, 1'b0);
    wait_done(base);
    repeat (5) tick();
    check_eq("ign_done_count", 32'(done_cnt - base), 32'd1);
    check_eq("ign_idle", 32'(busy), 32'd0);
    wait_drain();

`ifdef SHADOW_COLLECT_TIMEOUT_EN
    // watchdog: chain0 stalls after three bits
    base = done_cnt; ebase = en1_cnt;
    pulse_start();
    wait_dump(0);
    ch_in_vld = 2'b01; ch_in = 2'b01; tick();
    ch_in = 2'b01; tick();
    ch_in = 2'b00; tick();
    ch_in_vld = '0; ch_in = '0;
    expect_word(8'h03, 3, 0, 1'b1);
    wait_done(base);
    check_eq("tmo_set", 32'(tmo), 32'd1);
    check_eq("tmo_no_chain1", 32'(en1_cnt - ebase), 32'd0);
    wait_drain();
`else
    check_eq("tmo_tied", 32'(tmo), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
